// File: rtl/kbd_matrix_scan.sv
// 4x4 active-low keypad scanner: row sequencing, full-image debounce,
// and one-cycle press events drained lowest key index first.
module kbd_matrix_scan #(
   parameter int unsigned SCAN_DIV = 25000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   output logic [15:0] key_state,
   output logic        key_valid,
   output logic [3:0]  key_code
);

   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [3:0] DB = 4'(DEBOUNCE);

   logic [3:0]    sync1_q;
   logic [3:0]    col_s_q;
   logic [SW-1:0] slot_q, slot_d;
   logic [1:0]    r_q, r_d;
   logic [3:0]    row_q, row_d;
   logic [15:0]   raw_q, raw_d;
   logic [15:0]   prev_q, prev_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [15:0]   state_q, state_d;
   logic [15:0]   pend_q, pend_d;
   logic          valid_q, valid_d;
   logic [3:0]    code_q, code_d;

   logic          sample;
   logic          scan_done;
   logic [15:0]   img;
   logic [15:0]   newly;
   logic [15:0]   lowest;
   logic [3:0]    low_idx;

   always_comb begin
      sample    = (slot_q == SLOT_LAST);
      scan_done = sample && (r_q == 2'd3);
      slot_d    = sample ? '0 : slot_q + SW'(1);
      r_d       = sample ? r_q + 2'd1 : r_q;
      row_d     = ~(4'b0001 << r_d);

      // Merge the current row into the image so row 3 counts this scan.
      img = raw_q;
      img[{r_q, 2'b00} +: 4] = ~col_s_q;
      raw_d = sample ? img : raw_q;

      prev_d  = prev_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      newly   = '0;
      if (scan_done) begin
         prev_d = img;
         if (img != prev_q) begin
            cnt_d = 4'd1;
         end else if (cnt_q < DB) begin
            cnt_d = cnt_q + 4'd1;
         end
         if (cnt_d == DB) begin
            newly   = img & ~state_q;
            state_d = img;
         end
      end

      lowest  = pend_q & (~pend_q + 16'd1);
      low_idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (pend_q[i]) low_idx = 4'(i);
      end
      valid_d = |pend_q;
      code_d  = valid_d ? low_idx : code_q;
      pend_d  = (pend_q & ~lowest) | newly;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 4'hF;
         col_s_q <= 4'hF;
         slot_q  <= '0;
         r_q     <= '0;
         row_q   <= 4'b1110;
         raw_q   <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         state_q <= '0;
         pend_q  <= '0;
         valid_q <= 1'b0;
         code_q  <= '0;
      end else begin
         sync1_q <= col;
         col_s_q <= sync1_q;
         slot_q  <= slot_d;
         r_q     <= r_d;
         row_q   <= row_d;
         raw_q   <= raw_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         code_q  <= code_d;
      end
   end

   assign row       = row_q;
   assign key_state = state_q;
   assign key_valid = valid_q;
   assign key_code  = code_q;

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Bench for kbd_matrix_scan: per-cycle reference model of the scan,
// debounce and event drain, plus directed keypad scenarios.
module tb_kbd_matrix_scan;

   localparam int SD = 8;
   localparam int DB = 3;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] keys = '0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [15:0] key_state;
   logic        key_valid;
   logic [3:0]  key_code;

   int n_chk = 0;
   int n_fail = 0;
   int ev_q[$];

   // model state
   int          n = 0;
   int          mr;
   int          cnt = 0;
   int          m_code = 0;
   logic        m_valid = 1'b0;
   logic [15:0] kd1 = '0, kd2 = '0;
   logic [15:0] acc = '0, prev = '0;
   logic [15:0] ks = '0, pend = '0;

   always #5 clk = ~clk;

   // keypad: a driven-low row pulls the columns of its pressed keys low
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!row[r]) col = col & ~keys[r*4 +: 4];
      end
   end

   kbd_matrix_scan #(
      .SCAN_DIV (SD),
      .DEBOUNCE (DB)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .col       (col),
      .row       (row),
      .key_state (key_state),
      .key_valid (key_valid),
      .key_code  (key_code)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ev_at(input int i);
      return (i < ev_q.size()) ? ev_q[i] : -1;
   endfunction

   task automatic align(input int p);
      @(negedge clk);
      while (n % (4*SD) != p) @(negedge clk);
   endtask

   // Reference: edge n samples row (n/SD)%4 at slot SD-1 using the
   // keypad as it stood two edges earlier (synchroniser depth).
   initial forever begin
      @(posedge clk);
      if (!rstn) begin
         n = 0; cnt = 0; m_valid = 1'b0; m_code = 0;
         kd1 = '0; kd2 = '0; acc = '0; prev = '0; ks = '0; pend = '0;
      end else begin
         m_valid = (pend != 0);
         if (m_valid) begin
            for (int i = 15; i >= 0; i--) if (pend[i]) m_code = i;
            pend[m_code] = 1'b0;
         end
         if (n % SD == SD-1) begin
            mr = (n / SD) % 4;
            acc[mr*4 +: 4] = kd2[mr*4 +: 4];
            if (mr == 3) begin
               cnt = (acc != prev) ? 1 : ((cnt < DB) ? cnt + 1 : DB);
               prev = acc;
               if (cnt == DB) begin
                  pend = pend | (acc & ~ks);
                  ks = acc;
               end
            end
         end
         kd2 = kd1;
         kd1 = keys;
         n++;
      end
   end

   initial forever begin
      logic [3:0] exp_row;
      @(negedge clk);
      exp_row = ~(4'b0001 << ((n / SD) % 4));
      check("row", row, exp_row);
      check("key_state", key_state, ks);
      check("key_valid", key_valid, m_valid);
      if (m_valid) check("key_code", key_code, m_code);
      if (key_valid) ev_q.push_back(int'(key_code));
   end

   initial begin
      logic got;
      repeat (3) @(negedge clk);
      check("rst_row", row, 4'b1110);
      check("rst_state", key_state, 16'h0);
      #1 rstn = 1'b1;
      ev_q.delete();
      repeat (500) @(negedge clk);
      #1;
      check("idle_events", ev_q.size(), 0);

      align(0);
      #1 keys = 16'h0040;
      ev_q.delete();
      repeat (160) @(negedge clk);
      #1;
      check("single_events", ev_q.size(), 1);
      check("single_code", ev_at(0), 6);
      check("single_state", key_state, 16'h0040);

      keys = 16'h0;
      ev_q.delete();
      repeat (160) @(negedge clk);
      #1;
      check("release_events", ev_q.size(), 0);
      check("release_state", key_state, 16'h0);

      keys = 16'h8021;
      repeat (160) @(negedge clk);
      #1;
      check("multi_events", ev_q.size(), 3);
      check("multi_code0", ev_at(0), 0);
      check("multi_code1", ev_at(1), 5);
      check("multi_code2", ev_at(2), 15);
      check("multi_state", key_state, 16'h8021);
      keys = 16'h0;
      repeat (160) @(negedge clk);

      align(1);
      ev_q.delete();
      for (int i = 0; i < 10; i++) begin
         #1 keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
         repeat (20) @(negedge clk);
      end
      #1 keys = 16'h0008;
      check("bounce_events", ev_q.size(), 0);
      repeat (160) @(negedge clk);
      #1;
      check("bounce_after", ev_q.size(), 1);
      check("bounce_code", ev_at(0), 3);
      keys = 16'h0;
      repeat (160) @(negedge clk);

      #1 keys = 16'h1102;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = key_valid;
      end
      check("drain_seen", got, 1);
      check("drain_first", key_code, 1);
      #1 rstn = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_valid", key_valid, 0);
      check("mid_rst_code", key_code, 0);
      check("mid_rst_state", key_state, 16'h0);
      check("mid_rst_row", row, 4'b1110);
      #1 rstn = 1'b1;
      ev_q.delete();
      repeat (90) @(negedge clk);
      #1;
      check("mid_rst_quiet", ev_q.size(), 0);
      repeat (110) @(negedge clk);
      #1;
      check("redo_events", ev_q.size(), 3);
      check("redo_code0", ev_at(0), 1);
      check("redo_code1", ev_at(1), 8);
      check("redo_code2", ev_at(2), 12);

      for (int i = 0; i < 25; i++) begin
         logic [15:0] m;
         m = 16'h0;
         repeat ($urandom_range(3, 0)) m[$urandom_range(15, 0)] = 1'b1;
         keys = m;
         repeat ($urandom_range(150, 10)) @(negedge clk);
         #1;
      end
      keys = 16'h0;
      repeat (200) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/kbd_matrix_scan.md
# kbd_matrix_scan

Scanner for a 4x4 active-low keypad matrix. It drives one row low at a time, samples the columns, debounces the whole 16-key image, and emits one single-cycle press event per newly pressed key, together with its key code. It sits between the board keypad pins and the per-key edge/lockout logic, and it also exposes a debounced 16-bit key-state vector for level consumers. Clocked from div_res[1] (25 MHz).

## Interface
- SCAN_DIV, 25000: clock cycles each row stays driven (1 ms at 25 MHz); legal range ≥ 8.
- DEBOUNCE, 4: consecutive identical full scans required before the debounced state updates; legal range 1..15.
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- col  input  4  keypad column pins, active-low, externally pulled up, asynchronous to clk.
- row  output  4  keypad row drive, active-low, one-hot-low.
- key_state  output  16  debounced pressed map; bit row*4+col, 1 = pressed.
- key_valid  output  1  one-cycle press event strobe.
- key_code  output  4  index (row*4+col) of the key in the current event; meaningful only when key_valid = 1.

## Operation
- **Column synchroniser.** col passes through a 2-flop synchroniser (col_s). Only col_s is used.
- **Row sequencer.**
  - Slot counter runs 0..SCAN_DIV-1; row index r runs 0..3 and wraps 3→0.
  - row = ~(1<<r), registered.
  - r and row advance on the cycle after slot count SCAN_DIV-1.
- **Sampling.**
  - At slot count SCAN_DIV-1, raw[r*4+c] <= ~col_s[c] for c = 0..3.
  - Sampling this late allows settling time plus synchroniser delay.
- **Scan completion.** The scan completes at the row-3 sample. The compare uses the full 16-bit image including the row-3 bits just sampled; call it img.
- **Debounce.**
  - If img == prev_img: stable_cnt <= min(stable_cnt+1, DEBOUNCE).
  - Otherwise: stable_cnt <= 1.
  - prev_img <= img in both cases.
  - When the new stable_cnt equals DEBOUNCE, key_state <= img and newly = img & ~key_state (old value). Otherwise newly = 0.
  - While stable_cnt is saturated, key_state keeps being rewritten with the same value and newly stays 0.
- **Events.**
  - A 16-bit pending mask accumulates newly.
  - Each cycle with pending ≠ 0: key_valid = 1 and key_code = index of the lowest set bit of pending. That bit is cleared.
  - Same-cycle update: pending <= (pending & ~lowest) | newly.
  - Releases produce no events; they only clear key_state bits.
  - A key released before its pending event is emitted still gets its event.
- **Multiple keys.** Keys pressed in the same debounced update are emitted on consecutive cycles in ascending index order. Ghosting is not resolved; the sampled image is reported as-is.
- **Reset.** Clears:
  - synchroniser flops to 1111;
  - slot counter and r to 0; row = 1110;
  - raw, prev_img and key_state to 0; stable_cnt to 0;
  - pending to 0; key_valid to 0; key_code to 0.
- **Reset mid-operation.** Pending events are discarded. Scanning restarts at row 0.

## Timing
- Scan period: 4*SCAN_DIV cycles.
- A press held steady through DEBOUNCE consecutive full scans updates key_state at the row-3 sample of the DEBOUNCE-th scan.
- key_valid for the first new key rises 1 cycle after the key_state update. The k-th key of a simultaneous group (k from 0) rises k+1 cycles after the update.
- key_valid is registered. It may stay high on consecutive cycles only while several events drain.
- Worst-case press-to-event latency: (DEBOUNCE+1)*4*SCAN_DIV + 16 + 3 cycles, covering synchroniser, partial first scan and the drain.
- Release-to-key_state-clear latency follows the same debounce rule.
- Glitch behaviour:
  - A glitch shorter than one scan that is captured in a single sample resets stable_cnt to 1 on that scan. It restarts the count again on the next scan, because that scan differs from the glitched one.
  - Such a glitch never updates key_state.

## Test plan
Bench parameters: SCAN_DIV=8, DEBOUNCE=3 (scan period 32 cycles).
- **Reset.** Reset, then release with col = 1111. Required: row = 1110 after release, then row cycles 1101, 1011, 0111 every 8 cycles. key_state = 0. key_valid stays 0 for 500 cycles.
- **Single key.** Pull col[2] low whenever row[1] = 0 (key 6), steady from a scan start. Required: key_state = 16'h0040 at the row-3 sample of the 3rd scan. key_valid = 1 with key_code = 6 for exactly one cycle, 1 cycle later. No further events while the key is held.
- **Release.** Release key 6. Required: key_state returns to 0 after 3 identical scans, with no key_valid.
- **Simultaneous press.** Press keys 0, 5 and 15 simultaneously and steadily. Required: key_valid high for 3 consecutive cycles with key_code 0, then 5, then 15. key_state = 16'h8021.
- **Bounce.** Toggle key 3 every 20 cycles for 200 cycles, then hold it. Required: no event during bouncing. Exactly one event with key_code = 3 after 3 stable scans.
- **Reset mid-drain.** Assert rstn low for 2 cycles between the 1st and 2nd events of a 3-key group. Required: all outputs return to reset values and no further events occur. After re-debouncing, all 3 keys are reported again.
